// File: rtl/sat_pkg.sv
// sat_pkg: types and constants shared by the SAT node and its feeders.
//   MSG_*    : 2-bit message type codes on the node message bus
//   VAR_W    : variable id width
//   lit_t    : one literal {neg, vid}; the literal is true when the variable
//              equals !neg
//   clause_t : three literals, packed as {lit2, lit1, lit0}
package sat_pkg;

  localparam int VAR_W = 8;

  localparam logic [1:0] MSG_NONE              = 2'b00;
  localparam logic [1:0] MSG_FORK              = 2'b01;
  localparam logic [1:0] MSG_SUBSTITUTION_MASK = 2'b10;

  typedef struct packed {
    logic             neg;
    logic [VAR_W-1:0] vid;
  } lit_t;

  typedef lit_t [2:0] clause_t;

endpackage

// File: rtl/clause_lit_eval.sv
// clause_lit_eval: combinational evaluation of one clause against a single
// variable assignment.
//   clause_i  : clause under test
//   var_i     : assigned variable id
//   val_i     : assigned value
//   touched_o : at least one literal refers to var_i
//   mask_o    : bit i set when literal i is made false by the assignment
//   sat_o     : some literal is made true by the assignment
module clause_lit_eval
  import sat_pkg::*;
(
  input  clause_t          clause_i,
  input  logic [VAR_W-1:0] var_i,
  input  logic             val_i,
  output logic             touched_o,
  output logic [2:0]       mask_o,
  output logic             sat_o
);

  logic [2:0] match;

  always_comb begin
    match  = '0;
    mask_o = '0;
    sat_o  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      match[i]  = (clause_i[i].vid == var_i);
      // A positive literal (neg=0) is false when the value is 0, a negated one
      // when the value is 1, so "false" reduces to neg == val.
      mask_o[i] = match[i] && (clause_i[i].neg == val_i);
      sat_o     = sat_o | (match[i] && (clause_i[i].neg != val_i));
    end
    touched_o = |match;
  end

endmodule

// File: rtl/clause_mask_streamer.sv
// clause_mask_streamer: on each accepted variable assignment, walks the local
// clause table one entry per cycle and streams one MSG_SUBSTITUTION_MASK
// message per affected clause towards the SAT node, stalling on out_ready.
//
// Build option: define CLAUSE_EMIT_ALL_EN to emit a message for every valid
// clause (untouched ones carry mask 000, sat 0); otherwise only clauses that
// reference the assigned variable are reported.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   cfg_we/addr/clause     : clause table write (accepted only while idle)
//   cfg_err                : one-cycle pulse after a dropped write
//   asg_valid/ready/var/val: assignment handshake
//   out_valid/ready        : message handshake
//   out_msg_type/var/mask/sat/clause_idx : message payload
//   scan_done              : one-cycle pulse when a scan finishes
//   busy                   : scan in progress
//
// VAR_W must equal sat_pkg::VAR_W, since clause storage uses sat_pkg types.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for an assignment; config writes accepted
// ST_SCAN  | evaluating clause idx_q, loading the output register
// ST_DRAIN | last clause evaluated, waiting for its message to transfer
// ST_DONE  | scan_done pulse, returns to ST_IDLE
module clause_mask_streamer
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES = 16,
  parameter int CLAUSE_AW   = 4,
  parameter int VAR_W       = sat_pkg::VAR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CLAUSE_AW-1:0]   cfg_addr,
  input  logic [3*(VAR_W+1)-1:0] cfg_clause,
  output logic                   cfg_err,
  input  logic                   asg_valid,
  output logic                   asg_ready,
  input  logic [VAR_W-1:0]       asg_var,
  input  logic                   asg_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_msg_type,
  output logic [VAR_W-1:0]       out_var,
  output logic [2:0]             out_mask,
  output logic                   out_sat,
  output logic [CLAUSE_AW-1:0]   out_clause_idx,
  output logic                   scan_done,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CLAUSE_AW-1:0] idx_q, idx_d;
  logic [VAR_W-1:0]     var_q, var_d;
  logic                 val_q, val_d;
  logic                 ov_q, ov_d;
  logic [2:0]           mask_q, mask_d;
  logic                 sat_q, sat_d;
  logic [CLAUSE_AW-1:0] oidx_q, oidx_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [NUM_CLAUSES-1:0] clause_vld_q;
  clause_t                table_q [NUM_CLAUSES];

  logic       cfg_ok;
  logic       touched;
  logic [2:0] eval_mask;
  logic       eval_sat;
  logic       emit;
  logic       slot_free;
  logic       last_idx;

  // A write collides with an accepted assignment when both arrive in IDLE
  // together; the assignment wins and the write is reported as dropped.
  assign cfg_ok    = cfg_we && (state_q == ST_IDLE) && !asg_valid;
  assign cfg_err_d = cfg_we && !cfg_ok;

  clause_lit_eval u_eval (
    .clause_i  (table_q[idx_q]),
    .var_i     (var_q),
    .val_i     (val_q),
    .touched_o (touched),
    .mask_o    (eval_mask),
    .sat_o     (eval_sat)
  );

`ifdef CLAUSE_EMIT_ALL_EN
  assign emit = clause_vld_q[idx_q];
`else
  assign emit = clause_vld_q[idx_q] && touched;
`endif

  // The output register can take a new message when it is empty or its
  // current message leaves this cycle.
  assign slot_free = !ov_q || out_ready;
  assign last_idx  = (idx_q == CLAUSE_AW'(NUM_CLAUSES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    var_d   = var_q;
    val_d   = val_q;
    ov_d    = ov_q;
    mask_d  = mask_q;
    sat_d   = sat_q;
    oidx_d  = oidx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (asg_valid) begin
          var_d   = asg_var;
          val_d   = asg_val;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (slot_free) begin
          ov_d = emit;
          if (emit) begin
            mask_d = eval_mask;
            sat_d  = eval_sat;
            oidx_d = idx_q;
          end
          if (last_idx) begin
            state_d = emit ? ST_DRAIN : ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      var_q        <= '0;
      val_q        <= 1'b0;
      ov_q         <= 1'b0;
      mask_q       <= '0;
      sat_q        <= 1'b0;
      oidx_q       <= '0;
      cfg_err_q    <= 1'b0;
      clause_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      var_q     <= var_d;
      val_q     <= val_d;
      ov_q      <= ov_d;
      mask_q    <= mask_d;
      sat_q     <= sat_d;
      oidx_q    <= oidx_d;
      cfg_err_q <= cfg_err_d;
      if (cfg_ok) begin
        clause_vld_q[cfg_addr] <= 1'b1;
      end
    end
  end

  // Literal storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      table_q[cfg_addr] <= clause_t'(cfg_clause);
    end
  end

  assign cfg_err        = cfg_err_q;
  assign asg_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign scan_done      = (state_q == ST_DONE);
  assign out_valid      = ov_q;
  assign out_msg_type   = ov_q ? MSG_SUBSTITUTION_MASK : MSG_NONE;
  assign out_var        = var_q;
  assign out_mask       = mask_q;
  assign out_sat        = sat_q;
  assign out_clause_idx = oidx_q;

endmodule

// File: tb/tb_clause_mask_streamer.sv
module tb_clause_mask_streamer;
  import sat_pkg::*;

  localparam int N  = 16;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [26:0]       cfg_clause = '0;
  logic              cfg_err;
  logic              asg_valid = 1'b0;
  logic              asg_ready;
  logic [7:0]        asg_var = '0;
  logic              asg_val = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [1:0]        out_msg_type;
  logic [7:0]        out_var;
  logic [2:0]        out_mask;
  logic              out_sat;
  logic [AW-1:0]     out_clause_idx;
  logic              scan_done;
  logic              busy;

  always #5 clk = ~clk;

  clause_mask_streamer #(.NUM_CLAUSES(N), .CLAUSE_AW(AW), .VAR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_clause(cfg_clause), .cfg_err(cfg_err), .asg_valid(asg_valid),
    .asg_ready(asg_ready), .asg_var(asg_var), .asg_val(asg_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg_type(out_msg_type),
    .out_var(out_var), .out_mask(out_mask), .out_sat(out_sat),
    .out_clause_idx(out_clause_idx), .scan_done(scan_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_vld [N];
  logic [8:0] m_lit [N][3];

  typedef struct {
    int         idx;
    logic [2:0] mask;
    logic       sat;
    logic [7:0] vid;
  } msg_t;

  msg_t expq[$];
  int   got_idx[$];

  function automatic logic [8:0] lit(input bit neg, input int v);
    logic [7:0] vv;
    vv = v[7:0];
    return {neg, vv};
  endfunction

  // Truth value of a literal under var=b: a negated literal is !b, else b.
  function automatic void model_clause(input int c, input logic [7:0] v, input logic b,
                                       output logic hit, output logic [2:0] m, output logic s);
    logic lv;
    hit = 0; m = 3'b000; s = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_lit[c][i][7:0] == v) begin
        hit = 1;
        lv  = m_lit[c][i][8] ? !b : b;
        if (lv) s = 1;
        else    m[i] = 1'b1;
      end
    end
  endfunction

  function automatic void predict(input logic [7:0] v, input logic b);
    logic hit, s;
    logic [2:0] m;
    msg_t e;
    for (int c = 0; c < N; c++) begin
      model_clause(c, v, b, hit, m, s);
`ifdef CLAUSE_EMIT_ALL_EN
      if (m_vld[c]) begin
`else
      if (m_vld[c] && hit) begin
`endif
        e.idx = c; e.mask = m; e.sat = s; e.vid = v;
        expq.push_back(e);
      end
    end
  endfunction

  // ---------------- compare process ----------------
  int         sd_cnt = 0;
  int         ov_cnt = 0;
  bit         held = 0;
  logic [2:0] h_mask;
  logic       h_sat;
  logic [3:0] h_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (scan_done) sd_cnt++;
      if (out_valid) begin
        ov_cnt++;
        chk("msg_type", out_msg_type, MSG_SUBSTITUTION_MASK);
        if (held) begin
          chk("stall_idx",  out_clause_idx, h_idx);
          chk("stall_mask", out_mask, h_mask);
          chk("stall_sat",  out_sat, h_sat);
        end
        if (expq.size() == 0) begin
          chk("unexpected_msg_idx", out_clause_idx, -1);
        end else begin
          chk("msg_idx",  out_clause_idx, expq[0].idx);
          chk("msg_mask", out_mask, expq[0].mask);
          chk("msg_sat",  out_sat, expq[0].sat);
          chk("msg_var",  out_var, expq[0].vid);
        end
        if (out_ready) begin
          if (expq.size() != 0) void'(expq.pop_front());
          got_idx.push_back(int'(out_clause_idx));
          held = 0;
        end else begin
          held = 1; h_idx = out_clause_idx; h_mask = out_mask; h_sat = out_sat;
        end
      end else begin
        chk("msg_type_none", out_msg_type, MSG_NONE);
        held = 0;
      end
    end
  end

  bit rnd_ready = 0;
  always @(posedge clk) begin
    #2;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus tasks (start and end at posedge+1) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input logic [8:0] l0, input logic [8:0] l1, input logic [8:0] l2);
    cfg_we = 1; cfg_addr = a[AW-1:0]; cfg_clause = {l2, l1, l0};
    @(posedge clk);
    m_vld[a] = 1; m_lit[a][0] = l0; m_lit[a][1] = l1; m_lit[a][2] = l2;
    #1 cfg_we = 0;
    @(negedge clk);
    chk("cfg_err_idle_write", cfg_err, 0);
    step();
  endtask

  task automatic start_assign(input logic [7:0] v, input logic b);
    chk("asg_ready_idle", asg_ready, 1);
    asg_valid = 1; asg_var = v; asg_val = b;
    @(posedge clk);
    predict(v, b);
    #1 asg_valid = 0;
  endtask

  task automatic finish_assign(output int cyc, output int first_ov, output int busy_cnt);
    cyc = 0; first_ov = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (out_valid && first_ov == 0) first_ov = cyc;
    end while (!scan_done && cyc < 400);
    chk("scan_done_timeout", (cyc < 400), 1);
    chk("all_msgs_sent", expq.size(), 0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_msg_type"}, out_msg_type, MSG_NONE);
    chk({tag, "_mask"}, out_mask, 0);
    chk({tag, "_sat"}, out_sat, 0);
    chk({tag, "_idx"}, out_clause_idx, 0);
    chk({tag, "_var"}, out_var, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, fov, bc, sd0, ov0, k;
    bit found3;
    logic hit, s;
    logic [2:0] m;

    for (int c = 0; c < N; c++) m_vld[c] = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1;
    step();

    // Test 1: two touched clauses, back-to-back
    load(0, lit(0, 42), lit(1, 7), lit(0, 3));
    load(5, lit(1, 42), lit(0, 42), lit(0, 9));
    model_clause(0, 8'd42, 1'b0, hit, m, s);
    chk("pin_c0_hit", hit, 1); chk("pin_c0_mask", m, 3'b001); chk("pin_c0_sat", s, 0);
    model_clause(5, 8'd42, 1'b0, hit, m, s);
    chk("pin_c5_mask", m, 3'b010); chk("pin_c5_sat", s, 1);

    got_idx.delete();
    out_ready = 1;
    start_assign(8'd42, 1'b0);
    finish_assign(cyc, fov, bc);
    chk("t1_latency_first_valid", fov, 2);
    chk("t1_scan_done_bound", (cyc <= N + 2), 1);
    chk("t1_msg_count", got_idx.size(), 2);
    if (got_idx.size() == 2) begin
      chk("t1_first_idx", got_idx[0], 0);
      chk("t1_second_idx", got_idx[1], 5);
    end

    // Test 2: stall for 5 cycles on the first message
    out_ready = 0;
    start_assign(8'd42, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 20);
    chk("t2_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_idx", out_clause_idx, 0);
      chk("t2_hold_mask", out_mask, 3'b001);
      chk("t2_hold_valid", out_valid, 1);
      if (i < 4) @(negedge clk);
    end
    step();
    out_ready = 1;
    finish_assign(cyc, fov, bc);

    // Test 3: dropped writes (during scan, and colliding with acceptance)
    start_assign(8'd9, 1'b1);
    cfg_we = 1; cfg_addr = 4'd3; cfg_clause = {lit(0, 79), lit(0, 78), lit(0, 77)};
    @(posedge clk); #1 cfg_we = 0;
    @(negedge clk); chk("t3_cfg_err_scan", cfg_err, 1);
    @(negedge clk); chk("t3_cfg_err_pulse", cfg_err, 0);
    finish_assign(cyc, fov, bc);

    asg_valid = 1; asg_var = 8'd3; asg_val = 1'b1;
    cfg_we = 1; cfg_addr = 4'd3; cfg_clause = {lit(0, 79), lit(0, 78), lit(0, 77)};
    @(posedge clk);
    predict(8'd3, 1'b1);
    #1 asg_valid = 0; cfg_we = 0;
    @(negedge clk); chk("t3_cfg_err_accept", cfg_err, 1);
    finish_assign(cyc, fov, bc);

    got_idx.delete();
    start_assign(8'd77, 1'b0);
    finish_assign(cyc, fov, bc);
    found3 = 0;
    foreach (got_idx[i]) if (got_idx[i] == 3) found3 = 1;
    chk("t3_no_idx3", found3, 0);

    // Test 4: reset mid-scan after the first message
    start_assign(8'd42, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 20);
    chk("t4_first_valid", out_valid, 1);
    @(posedge clk); #1 rst_n = 0;
    expq.delete();
    for (int c = 0; c < N; c++) m_vld[c] = 0;
    #1 check_reset_outputs("midreset");
    sd0 = sd_cnt;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_scan_done", scan_done, 0);
      chk("t4_idle_after_reset", busy, 0);
    end
    step();
    chk("t4_scan_done_count", sd_cnt - sd0, 0);
    ov0 = ov_cnt;
    start_assign(8'd42, 1'b0);
    finish_assign(cyc, fov, bc);
    chk("t4_post_reset_no_msgs", ov_cnt - ov0, 0);

    // Test 5: empty table
    ov0 = ov_cnt; sd0 = sd_cnt;
    start_assign(8'd1, 1'b1);
    finish_assign(cyc, fov, bc);
    step(); step();
    chk("t5_no_valid", ov_cnt - ov0, 0);
    chk("t5_one_scan_done", sd_cnt - sd0, 1);
    chk("t5_busy_len", (bc >= N && bc <= N + 2), 1);

    // Test 6: four valid clauses, assignment matches none
    for (int c = 0; c < 4; c++)
      load(c, lit(0, $urandom_range(0, 150)), lit(1, $urandom_range(0, 150)), lit(0, $urandom_range(0, 150)));
    got_idx.delete();
    start_assign(8'd200, 1'b1);
    finish_assign(cyc, fov, bc);
`ifdef CLAUSE_EMIT_ALL_EN
    chk("t6_msg_count", got_idx.size(), 4);
    foreach (got_idx[i]) chk("t6_idx_order", got_idx[i], i);
`else
    chk("t6_msg_count", got_idx.size(), 0);
`endif

    // Random phase: small variable range so clauses are often touched
    rnd_ready = 1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        load($urandom_range(0, N - 1),
             lit($urandom_range(0, 1), $urandom_range(0, 5)),
             lit($urandom_range(0, 1), $urandom_range(0, 5)),
             lit($urandom_range(0, 1), $urandom_range(0, 5)));
      start_assign(8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      finish_assign(cyc, fov, bc);
    end
    rnd_ready = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
